// File: rtl/axis_detector_writer.sv
// -----------------------------------------------------------------------------
// axis_detector_writer
//
// Replays recorded detector hit events onto the detector bus. Each 128-bit
// AXI4-Stream word carries {timestamp, hit pattern}. The block holds the event
// until its free-running cycle timer reaches the timestamp. It then drives the
// hit pattern for L+1 cycles, followed by at least one all-zero cycle.
//
// Compile-time option:
//   DETECTOR_WRITER_LATE_DROP_EN
//     defined   : an event whose timestamp has already passed is dropped and
//                 counted in sts_late (saturating).
//     undefined : a late event is emitted at once, and sts_late reads 0.
//
// Ports:
//   aclk           in   system clock, rising edge
//   aresetn        in   asynchronous active-low reset
//   cfg_data       in   [7:0] pulse length minus one (L), [8] run enable
//   s_axis_tdata   in   [TIME+DATA-1:DATA] timestamp, [DATA-1:0] hit pattern
//   s_axis_tvalid  in   event valid
//   s_axis_tready  out  registered ready; depends only on state and enable
//   det_data       out  registered detector output
//   sts_time       out  current timer value (held at 0 while disabled)
//   sts_late       out  number of dropped late events
//   dbg_state      out  FSM state (0 IDLE, 1 WAIT, 2 PULSE, 3 GAP)
//
// Handshake: an event is transferred on a rising edge where s_axis_tvalid and
// s_axis_tready are both high. The source must hold tdata stable while tvalid
// is high and no transfer has happened. tready never looks at tvalid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_detector_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int TIME_WIDTH = 64
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [8:0]                       cfg_data,
    input  logic [TIME_WIDTH+DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic [DATA_WIDTH-1:0]            det_data,
    output logic [TIME_WIDTH-1:0]            sts_time,
    output logic [31:0]                      sts_late,
    output logic [1:0]                       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_PULSE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [TIME_WIDTH-1:0] TIME_ONE = {{(TIME_WIDTH-1){1'b0}}, 1'b1};

    logic                  enable;
    logic [7:0]            pulse_len;

    state_t                state_q;
    logic [TIME_WIDTH-1:0] time_q;
    logic [TIME_WIDTH-1:0] time_d;
    logic [TIME_WIDTH-1:0] ev_time_q;
    logic [DATA_WIDTH-1:0] ev_data_q;
    logic [DATA_WIDTH-1:0] det_q;
    logic [7:0]            cnt_q;
    logic                  ready_q;

    assign enable    = cfg_data[8];
    assign pulse_len = cfg_data[7:0];

    // ------------------------------------------------------------------------
    // Free-running timer: cleared while disabled, wraps naturally.
    // ------------------------------------------------------------------------
    assign time_d = enable ? (time_q + TIME_ONE) : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    // ------------------------------------------------------------------------
    // Event FSM. Disable has priority over everything and throws away any
    // latched event.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            ev_time_q <= '0;
            ev_data_q <= '0;
            det_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
        end else if (!enable) begin
            state_q   <= S_IDLE;
            det_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (s_axis_tvalid && ready_q) begin
                        ev_time_q <= s_axis_tdata[TIME_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                        ev_data_q <= s_axis_tdata[DATA_WIDTH-1:0];
                        ready_q   <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (time_q == ev_time_q) begin
                        det_q   <= ev_data_q;
                        cnt_q   <= '0;
                        state_q <= S_PULSE;
                    end else if (time_q > ev_time_q) begin
`ifdef DETECTOR_WRITER_LATE_DROP_EN
                        // Timestamp already passed: drop it and reopen input.
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
`else
                        // Timestamp already passed: play it out right away.
                        det_q   <= ev_data_q;
                        cnt_q   <= '0;
                        state_q <= S_PULSE;
`endif
                    end
                end
                S_PULSE: begin
                    // L is read live, so a shortened L ends the pulse at once.
                    if (cnt_q >= pulse_len) begin
                        det_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Late-event counter. It survives disable and clears only on reset.
    // ------------------------------------------------------------------------
`ifdef DETECTOR_WRITER_LATE_DROP_EN
    logic [31:0] late_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            late_q <= '0;
        end else if (enable && (state_q == S_WAIT) && (time_q > ev_time_q)
                     && (late_q != 32'hFFFF_FFFF)) begin
            late_q <= late_q + 32'd1;
        end
    end

    assign sts_late = late_q;
`else
    assign sts_late = 32'd0;
`endif

    assign s_axis_tready = ready_q;
    assign det_data      = det_q;
    assign sts_time      = time_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_detector_writer.sv
`timescale 1ns/1ps

module tb_axis_detector_writer;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic          aclk = 1'b0;
    logic          aresetn;
    logic [8:0]    cfg_data;
    logic [127:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   det_data;
    logic [63:0]   sts_time;
    logic [31:0]   sts_late;
    logic [1:0]    dbg_state;

    always #5 aclk = ~aclk;

    axis_detector_writer #(
        .DATA_WIDTH(64),
        .TIME_WIDTH(64)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .det_data      (det_data),
        .sts_time      (sts_time),
        .sts_late      (sts_late),
        .dbg_state     (dbg_state)
    );

`ifdef DETECTOR_WRITER_LATE_DROP_EN
    localparam bit LATE_DROP = 1'b1;
`else
    localparam bit LATE_DROP = 1'b0;
`endif

    // Reference timer: counts while enabled, cleared while disabled or reset.
    logic [63:0] model_time;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn)         model_time <= 64'd0;
        else if (cfg_data[8]) model_time <= model_time + 64'd1;
        else                  model_time <= 64'd0;
    end

    // Handshake counter.
    int hs_count = 0;
    always @(posedge aclk) begin
        if (aresetn && s_axis_tvalid && s_axis_tready) hs_count++;
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        exp_rdy_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected det_data at timer value t for an on-time event (T, D, L).
    function automatic logic [63:0] pexp(input logic [63:0] t, input logic [63:0] tt,
                                         input logic [63:0] d, input int l);
        return (t >= tt + 64'd1 && t <= tt + 64'(l) + 64'd1) ? d : 64'd0;
    endfunction

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic wait_time(input logic [63:0] t);
        int n = 0;
        @(negedge aclk);
        while (model_time != t && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("wait_time", model_time, t);
    endtask

    // Call between edges; returns #1 after the handshake edge.
    task automatic send_event(input logic [63:0] t, input logic [63:0] d, input bit keep);
        int n = 0;
        s_axis_tdata  = {t, d};
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("hs_wait", 64'(n < 200), 64'd1);
        @(posedge aclk);
        #1;
        if (!keep) s_axis_tvalid = 1'b0;
    endtask

    // Samples n consecutive negedges from timer value t0 against exp_q.
    task automatic run_window(input logic [63:0] t0, input int n, input bit with_rdy);
        wait_time(t0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge aclk);
            check("det_data", det_data, exp_q.pop_front());
            if (with_rdy) check("tready", 64'(s_axis_tready), 64'(exp_rdy_q.pop_front()));
        end
    endtask

    task automatic restart_timer(input logic [7:0] l);
        @(negedge aclk);
        cfg_data = {1'b0, l};
        @(negedge aclk);
        check("timer_cleared", sts_time, 64'd0);
        check("rdy_disabled", 64'(s_axis_tready), 64'd0);
        cfg_data = {1'b1, l};
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int hs_base;
        aresetn       = 1'b0;
        cfg_data      = 9'd0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset state
        check("rst_det", det_data, 64'd0);
        check("rst_rdy", 64'(s_axis_tready), 64'd0);
        check("rst_time", sts_time, 64'd0);
        check("rst_late", 64'(sts_late), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        aresetn = 1'b1;

        // Single on-time event, L=3, T=20
        cfg_data = {1'b1, 8'd3};
        send_event(64'd20, 64'h1, 1'b0);
        for (int t = 19; t <= 26; t++) exp_q.push_back(pexp(64'(t), 64'd20, 64'h1, 3));
        run_window(64'd19, 8, 1'b0);
        check("timer_track", sts_time, model_time);
        check("late_t1", 64'(sts_late), 64'd0);

        // Back-to-back at the minimum spacing, L=0
        restart_timer(8'd0);
        fork
            begin
                send_event(64'd10, 64'h5, 1'b0);
                send_event(64'd14, 64'hA0, 1'b0);
            end
            begin
                for (int t = 9; t <= 17; t++)
                    exp_q.push_back(pexp(64'(t), 64'd10, 64'h5, 0) | pexp(64'(t), 64'd14, 64'hA0, 0));
                run_window(64'd9, 9, 1'b0);
            end
        join
        check("late_b2b", 64'(sts_late), 64'd0);

        // Late event: T=5 at timer 50, L=2
        cfg_data = {1'b1, 8'd2};
        wait_time(64'd50);
        send_event(64'd5, 64'hF, 1'b0);
        for (int t = 51; t <= 57; t++) begin
            exp_q.push_back(LATE_DROP ? 64'd0 : pexp(64'(t), 64'd51, 64'hF, 2));
            exp_rdy_q.push_back(t == 51 ? 1'b0 : (LATE_DROP ? 1'b1 : (t >= 56)));
        end
        run_window(64'd51, 7, 1'b1);
        check("late_count", 64'(sts_late), LATE_DROP ? 64'd1 : 64'd0);

        // Disable in the middle of a long pulse, L=10
        restart_timer(8'd10);
        send_event(64'd8, 64'h3C, 1'b0);
        wait_time(64'd12);
        check("mid_pulse", det_data, 64'h3C);
        cfg_data = {1'b0, 8'd10};
        @(negedge aclk);
        check("dis_det", det_data, 64'd0);
        check("dis_rdy", 64'(s_axis_tready), 64'd0);
        check("dis_time", sts_time, 64'd0);
        check("dis_state", 64'(dbg_state), 64'd0);
        check("dis_late_kept", 64'(sts_late), LATE_DROP ? 64'd1 : 64'd0);
        cfg_data = {1'b1, 8'd1};
        send_event(64'd6, 64'h77, 1'b0);
        for (int t = 5; t <= 10; t++) exp_q.push_back(pexp(64'(t), 64'd6, 64'h77, 1));
        run_window(64'd5, 6, 1'b0);

        // Asynchronous reset in the middle of a pulse, L=10
        cfg_data = {1'b1, 8'd10};
        send_event(64'd20, 64'hFF, 1'b0);
        wait_time(64'd23);
        check("pre_rst_pulse", det_data, 64'hFF);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_det", det_data, 64'd0);
        check("arst_rdy", 64'(s_axis_tready), 64'd0);
        check("arst_time", sts_time, 64'd0);
        check("arst_late", 64'(sts_late), 64'd0);
        cfg_data = {1'b1, 8'd2};
        @(negedge aclk);
        aresetn = 1'b1;

        // tvalid held high across pulses: one event per pass, L=2
        hs_base = hs_count;
        fork
            begin
                send_event(64'd10, 64'h11, 1'b1);
                send_event(64'd16, 64'h22, 1'b1);
                send_event(64'd22, 64'h33, 1'b0);
            end
            begin
                for (int t = 9; t <= 27; t++)
                    exp_q.push_back(pexp(64'(t), 64'd10, 64'h11, 2) |
                                    pexp(64'(t), 64'd16, 64'h22, 2) |
                                    pexp(64'(t), 64'd22, 64'h33, 2));
                run_window(64'd9, 19, 1'b0);
            end
        join
        check("hs_count", 64'(hs_count - hs_base), 64'd3);
        check("late_hold", 64'(sts_late), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/axis_detector_writer.md
# axis_detector_writer

Replays detector hit events onto the 64-bit detector bus. Consumes an AXI4-Stream of 128-bit `{time, data}` event words, holds each event until a free-running 64-bit cycle timer reaches the event's timestamp, then drives the hit pattern for a programmable number of cycles. Used as the stimulus/emulation end of the detector path: its `det_data` feeds the detector reader input, for loopback self-test and for playback of recorded runs.

## Interface
- `DATA_WIDTH`, 64, width of the hit pattern and of `det_data`.
- `TIME_WIDTH`, 64, width of the timestamp and of the internal timer.
- `aclk`  in  1  system clock; all logic is on its rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `cfg_data`  in  9  [7:0] pulse length minus one (L); [8] run enable.
- `s_axis_tdata`  in  TIME_WIDTH+DATA_WIDTH  event; [127:64] timestamp, [63:0] hit pattern.
- `s_axis_tvalid`  in  1  event valid.
- `s_axis_tready`  out  1  event accepted when high together with tvalid.
- `det_data`  out  DATA_WIDTH  registered detector output.
- `sts_time`  out  TIME_WIDTH  current timer value.
- `sts_late`  out  32  count of dropped late events; reads 0 when the late-drop feature is compiled out.

## Operation
- Timer: `sts_time` increments by 1 every cycle while `cfg_data[8]`=1. It is held at 0 while `cfg_data[8]`=0. It wraps modulo 2^64, and wrap is not handled.
- State machine:
  - IDLE: tready=1 when enabled. On handshake, latch timestamp T and pattern D, then go to WAIT.
  - WAIT: tready=0. If `sts_time`==T, load `det_data`<=D, clear the pulse counter, and go to PULSE. If `sts_time`>T (unsigned), the event is late; handling is per Configuration.
  - PULSE: `det_data` holds D and the counter increments. When counter>=L, `det_data`<=0 and go to GAP.
  - GAP: one cycle with `det_data`=0, then go to IDLE. This guarantees a zero cycle between consecutive pulses.
- D=0 is legal: the block traverses the same states with `det_data` staying 0.
- Disable (`cfg_data[8]` falls) in any state: on the next edge go to IDLE, set `det_data`=0 and tready=0, and discard any latched event. `sts_late` is not cleared.
- `cfg_data[7:0]` is sampled each PULSE cycle. Changes during a pulse take effect immediately.

## Timing
- Reset values: `det_data`=0, `s_axis_tready`=0, `sts_time`=0, `sts_late`=0, state IDLE.
- Reset is asynchronous and may assert mid-pulse; `det_data` returns to 0 immediately.
- Handshake at edge where `sts_time`=t, followed by WAIT at t+1. An event with T<=t is therefore late.
- On-time event: `det_data`=D becomes visible on the edge after the cycle where `sts_time`==T. It is held for exactly L+1 cycles, followed by at least 1 zero cycle.
- Minimum event-to-event period is L+4 cycles (PULSE L+1, GAP 1, IDLE 1, WAIT 1). Events spaced closer arrive late.
- tready is registered and depends only on state and enable. It never depends combinationally on tvalid.
- `sts_late` saturates at 2^32-1.

## Configuration
- `DETECTOR_WRITER_LATE_DROP_EN` defined: a late event in WAIT is discarded. The block returns to IDLE, increments `sts_late`, and drives no pulse.
- Not defined: a late event is emitted at once, with PULSE entered from WAIT as if on time. `sts_late` is tied to 0.

## Test plan
- Reset, enable, L=3; send T=20, D=0x1. Required: `det_data`=0x1 for exactly 4 cycles starting at the edge after `sts_time`==20, then 0.
- Back-to-back events T=10 and T=14 with L=0 (spacing equals the L+4 minimum). Required: two 1-cycle pulses, both on time, separated by 3 zero cycles; `sts_late`=0.
- Send T=5 when `sts_time`≈50, with the macro defined. Required: no pulse, `sts_late`=1, tready high again 2 cycles after the handshake. Without the macro: pulse of L+1 cycles starting 2 cycles after the handshake.
- Deassert enable in mid-PULSE with L=10. Required: `det_data`=0 on the next edge, tready=0, `sts_time`=0; re-enable accepts a new event normally.
- Assert `aresetn`=0 asynchronously mid-pulse. Required: `det_data`, tready and `sts_time` are 0 before the next clock edge.
- tvalid held high across PULSE. Required: no handshake until IDLE, exactly one event consumed per pass through the state machine.
